// File: rtl/control_sequencer.sv
// Hardwired control unit for the 32-bit datapath: one state per clock, Moore
// strobes decoded from the registered state and the instruction class in IR.
module control_sequencer (
    input  logic        Clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        Stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        Cout,
    output logic [4:0]  alu_op,
    output logic        Run,
    output logic        illegal
);

    localparam logic [3:0] ST_RESET  = 4'd0;
    localparam logic [3:0] ST_T0     = 4'd1;
    localparam logic [3:0] ST_T1     = 4'd2;
    localparam logic [3:0] ST_T2     = 4'd3;
    localparam logic [3:0] ST_T3     = 4'd4;
    localparam logic [3:0] ST_T4     = 4'd5;
    localparam logic [3:0] ST_T5     = 4'd6;
    localparam logic [3:0] ST_T6     = 4'd7;
    localparam logic [3:0] ST_HALTED = 4'd8;

    localparam logic [2:0] CL_ALU3    = 3'd0;
    localparam logic [2:0] CL_IMM     = 3'd1;
    localparam logic [2:0] CL_MULDIV  = 3'd2;
    localparam logic [2:0] CL_UNARY   = 3'd3;
    localparam logic [2:0] CL_NOP     = 3'd4;
    localparam logic [2:0] CL_HALT    = 3'd5;
    localparam logic [2:0] CL_ILLEGAL = 3'd6;

    logic [3:0] state_r;
    logic [3:0] state_next_s;
    logic [3:0] boundary_s;
    logic [2:0] class_s;
    logic [4:0] opcode_s;
    logic       illegal_r;

    assign opcode_s   = IR[31:27];
    assign boundary_s = Stop ? ST_HALTED : ST_T0;
    assign illegal    = illegal_r;

    // Instruction class from the opcode field
    always_comb begin
        class_s = CL_ILLEGAL;
        if ((opcode_s >= 5'b00011) && (opcode_s <= 5'b01011)) begin
            class_s = CL_ALU3;
        end else if ((opcode_s >= 5'b01100) && (opcode_s <= 5'b01110)) begin
            class_s = CL_IMM;
        end else if ((opcode_s == 5'b01111) || (opcode_s == 5'b10000)) begin
            class_s = CL_MULDIV;
        end else if ((opcode_s == 5'b10001) || (opcode_s == 5'b10010)) begin
            class_s = CL_UNARY;
        end else if (opcode_s == 5'b11010) begin
            class_s = CL_NOP;
        end else if (opcode_s == 5'b11011) begin
            class_s = CL_HALT;
        end else begin
            class_s = CL_ILLEGAL;
        end
    end

    // Next-state sequencing; Stop only acts at instruction boundaries
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RESET: state_next_s = boundary_s;
            ST_T0:    state_next_s = ST_T1;
            ST_T1:    state_next_s = ST_T2;
            ST_T2:    state_next_s = ST_T3;
            ST_T3: begin
                case (class_s)
                    CL_HALT:                  state_next_s = ST_HALTED;
                    CL_NOP, CL_ILLEGAL:       state_next_s = boundary_s;
                    default:                  state_next_s = ST_T4;
                endcase
            end
            ST_T4:    state_next_s = (class_s == CL_UNARY) ? boundary_s : ST_T5;
            ST_T5:    state_next_s = (class_s == CL_MULDIV) ? ST_T6 : boundary_s;
            ST_T6:    state_next_s = boundary_s;
            ST_HALTED: state_next_s = ST_HALTED;
            default:  state_next_s = ST_RESET;
        endcase
    end

    // State register and sticky illegal flag, both cleared asynchronously
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_r   <= ST_RESET;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_T3) && (class_s == CL_ILLEGAL)) begin
                illegal_r <= 1'b1;
            end else begin
                illegal_r <= illegal_r;
            end
        end
    end

    // Moore strobe decode; anything not named for a state stays 0
    always_comb begin
        {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin} = 8'b0;
        {Yin, Zin, Zlowout, Zhighout, HIin, LOin} = 6'b0;
        {Gra, Grb, Grc, Rin, Rout, Cout} = 6'b0;
        alu_op = 5'b00000;
        Run = (state_r >= ST_T0) && (state_r <= ST_T6);
        case (state_r)
            ST_T0: {PCout, MARin, IncPC, PCin} = 4'b1111;
            ST_T1: {Read, MDRin} = 2'b11;
            ST_T2: {MDRout, IRin} = 2'b11;
            ST_T3: begin
                case (class_s)
                    CL_ALU3, CL_IMM: {Grb, Rout, Yin} = 3'b111;
                    CL_MULDIV:       {Gra, Rout, Yin} = 3'b111;
                    CL_UNARY: begin
                        {Grb, Rout, Zin} = 3'b111;
                        alu_op = opcode_s;
                    end
                    default: Run = 1'b1;
                endcase
            end
            ST_T4: begin
                case (class_s)
                    CL_ALU3: begin
                        {Grc, Rout, Zin} = 3'b111;
                        alu_op = opcode_s;
                    end
                    CL_IMM: begin
                        {Cout, Zin} = 2'b11;
                        alu_op = opcode_s;
                    end
                    CL_MULDIV: begin
                        {Grb, Rout, Zin} = 3'b111;
                        alu_op = opcode_s;
                    end
                    CL_UNARY: {Zlowout, Gra, Rin} = 3'b111;
                    default:  Run = 1'b1;
                endcase
            end
            ST_T5: begin
                case (class_s)
                    CL_ALU3, CL_IMM: {Zlowout, Gra, Rin} = 3'b111;
                    CL_MULDIV:       {Zlowout, LOin} = 2'b11;
                    default:         Run = 1'b1;
                endcase
            end
            ST_T6: {Zhighout, HIin} = 2'b11;
            default: Run = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch/execute sequences per
// instruction class and checks strobes, alu_op, Run and illegal each cycle.
module tb_control_sequencer;

    logic        Clock;
    logic        clear;
    logic [31:0] IR;
    logic        Stop;
    logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic Gra, Grb, Grc, Rin, Rout, Cout;
    logic [4:0] alu_op;
    logic Run, illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [19:0] S_PCOUT = 20'h80000, S_PCIN = 20'h40000, S_INCPC = 20'h20000, S_MARIN = 20'h10000;
    localparam logic [19:0] S_READ = 20'h08000, S_MDRIN = 20'h04000, S_MDROUT = 20'h02000, S_IRIN = 20'h01000;
    localparam logic [19:0] S_YIN = 20'h00800, S_ZIN = 20'h00400, S_ZLOW = 20'h00200, S_ZHIGH = 20'h00100;
    localparam logic [19:0] S_HIIN = 20'h00080, S_LOIN = 20'h00040, S_GRA = 20'h00020, S_GRB = 20'h00010;
    localparam logic [19:0] S_GRC = 20'h00008, S_RIN = 20'h00004, S_ROUT = 20'h00002, S_COUT = 20'h00001;
    localparam logic [19:0] S_NONE = 20'h00000;
    localparam logic [19:0] F_T0 = S_PCOUT | S_PCIN | S_INCPC | S_MARIN;
    localparam logic [19:0] F_T1 = S_READ | S_MDRIN;
    localparam logic [19:0] F_T2 = S_MDROUT | S_IRIN;

    control_sequencer dut (
        .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .Rin(Rin), .Rout(Rout), .Cout(Cout), .alu_op(alu_op),
        .Run(Run), .illegal(illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic check(input string tag, input logic [19:0] exp_s,
                         input logic [4:0] exp_op, input logic exp_run, input logic exp_ill);
        logic [26:0] observed;
        logic [26:0] expected;
        observed = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                    Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                    Gra, Grb, Grc, Rin, Rout, Cout, alu_op, Run, illegal};
        expected = {exp_s, exp_op, exp_run, exp_ill};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic fetch(input string tag, input logic ill);
        check({tag, "_t0"}, F_T0, 5'b00000, 1'b1, ill);
        step(); check({tag, "_t1"}, F_T1, 5'b00000, 1'b1, ill);
        step(); check({tag, "_t2"}, F_T2, 5'b00000, 1'b1, ill);
        step();
    endtask

    initial begin
        clear = 1'b1;
        Stop  = 1'b0;
        IR    = 32'h28918000;
        #3;
        check("reset", S_NONE, 5'b00000, 1'b0, 1'b0);
        @(negedge Clock);
        check("reset_hold", S_NONE, 5'b00000, 1'b0, 1'b0);
        clear = 1'b0;
        step();

        // and R1,R2,R3
        fetch("and", 1'b0);
        check("and_t3", S_GRB | S_ROUT | S_YIN, 5'b00000, 1'b1, 1'b0);
        step(); check("and_t4", S_GRC | S_ROUT | S_ZIN, 5'b00101, 1'b1, 1'b0);
        step(); check("and_t5", S_ZLOW | S_GRA | S_RIN, 5'b00000, 1'b1, 1'b0);
        step();

        // mul R3,R1
        IR = 32'h79880000;
        fetch("mul", 1'b0);
        check("mul_t3", S_GRA | S_ROUT | S_YIN, 5'b00000, 1'b1, 1'b0);
        step(); check("mul_t4", S_GRB | S_ROUT | S_ZIN, 5'b01111, 1'b1, 1'b0);
        step(); check("mul_t5", S_ZLOW | S_LOIN, 5'b00000, 1'b1, 1'b0);
        step(); check("mul_t6", S_ZHIGH | S_HIIN, 5'b00000, 1'b1, 1'b0);
        step();

        // addi
        IR = 32'h60000000;
        fetch("addi", 1'b0);
        check("addi_t3", S_GRB | S_ROUT | S_YIN, 5'b00000, 1'b1, 1'b0);
        step(); check("addi_t4", S_COUT | S_ZIN, 5'b01100, 1'b1, 1'b0);
        step(); check("addi_t5", S_ZLOW | S_GRA | S_RIN, 5'b00000, 1'b1, 1'b0);
        step();

        // neg
        IR = 32'h88000000;
        fetch("neg", 1'b0);
        check("neg_t3", S_GRB | S_ROUT | S_ZIN, 5'b10001, 1'b1, 1'b0);
        step(); check("neg_t4", S_ZLOW | S_GRA | S_RIN, 5'b00000, 1'b1, 1'b0);
        step();

        // nop
        IR = 32'hD0000000;
        fetch("nop", 1'b0);
        check("nop_t3", S_NONE, 5'b00000, 1'b1, 1'b0);
        step();

        // illegal opcode 00000
        IR = 32'h00000000;
        fetch("ill", 1'b0);
        check("ill_t3", S_NONE, 5'b00000, 1'b1, 1'b0);
        step();

        // illegal stays set across the next instruction; clear mid-T4
        IR = 32'h28918000;
        fetch("sticky", 1'b1);
        check("sticky_t3", S_GRB | S_ROUT | S_YIN, 5'b00000, 1'b1, 1'b1);
        step(); check("sticky_t4", S_GRC | S_ROUT | S_ZIN, 5'b00101, 1'b1, 1'b1);
        #2 clear = 1'b1;
        #1 check("async_clear", S_NONE, 5'b00000, 1'b0, 1'b0);
        @(negedge Clock);
        check("clear_held", S_NONE, 5'b00000, 1'b0, 1'b0);
        clear = 1'b0;
        step();

        // Stop raised during T4 completes the instruction, then halts
        fetch("stop", 1'b0);
        check("stop_t3", S_GRB | S_ROUT | S_YIN, 5'b00000, 1'b1, 1'b0);
        step(); check("stop_t4", S_GRC | S_ROUT | S_ZIN, 5'b00101, 1'b1, 1'b0);
        Stop = 1'b1;
        step(); check("stop_t5", S_ZLOW | S_GRA | S_RIN, 5'b00000, 1'b1, 1'b0);
        step(); check("stop_halted", S_NONE, 5'b00000, 1'b0, 1'b0);
        Stop = 1'b0;
        step(); check("stop_no_resume", S_NONE, 5'b00000, 1'b0, 1'b0);

        // halt instruction
        clear = 1'b1;
        IR = 32'hD8000000;
        step();
        clear = 1'b0;
        step();
        fetch("halt", 1'b0);
        check("halt_t3", S_NONE, 5'b00000, 1'b1, 1'b0);
        step(); check("halt_halted", S_NONE, 5'b00000, 1'b0, 1'b0);
        step(); check("halt_stays", S_NONE, 5'b00000, 1'b0, 1'b0);

        // reset release with Stop high goes straight to HALTED
        clear = 1'b1;
        Stop  = 1'b1;
        IR    = 32'h28918000;
        step();
        clear = 1'b0;
        step(); check("release_stop", S_NONE, 5'b00000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
